servo_pwm_posicao: RTL



---
 rtl/servo_pwm_posicao.sv | 120 ++++++++++++
 1 files changed

// File: rtl/servo_pwm_posicao.sv
// Servo PWM generator: pulse width LARGURA_MIN + posicao*PASSO, repeated every PERIODO cycles.
// Optional SERVO_INVERTE_EN inverts the pwm output polarity for open-collector shifters.
module servo_pwm_posicao #(
    parameter int PERIODO     = 1000000,
    parameter int LARGURA_MIN = 50000,
    parameter int PASSO       = 1000,
    parameter int M           = 50,
    parameter int N           = 6,
    parameter int W           = 20
) (
    input  logic         clock,
    input  logic         zera_as_n,
    input  logic         zera_s,
    input  logic         habilita,
    input  logic [N-1:0] posicao,
    output logic         pwm,
    output logic         fim_periodo,
    output logic [N-1:0] posicao_atual,
    output logic         ativo
);

    typedef enum logic [1:0] {INATIVO, PULSO, ESPERA} estado_t;

    localparam logic [W-1:0] ULTIMO  = W'(PERIODO - 1);
    localparam logic [N-1:0] POS_MAX = N'(M - 1);

    estado_t        estado_q;
    logic [W-1:0]   contador_q;
    logic           pwm_q;
    logic           fim_q;
    logic           ativo_q;
    logic [N-1:0]   posicao_q;

    logic [N-1:0]   posicao_sat;
    logic [W-1:0]   largura;
    logic [W-1:0]   contador_inc;

    // Out-of-range requests clamp to the last valid position instead of wrapping.
    assign posicao_sat  = (32'(posicao) >= 32'(M)) ? POS_MAX : posicao;
    assign largura      = W'(LARGURA_MIN) + W'(posicao_q) * W'(PASSO);
    assign contador_inc = contador_q + W'(1);

    // NOTE: state registers use non-blocking assignments so every register samples
    // the pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clock or negedge zera_as_n) begin
        if (!zera_as_n) begin
            estado_q   <= INATIVO;
            contador_q <= '0;
            pwm_q      <= 1'b0;
            fim_q      <= 1'b0;
            ativo_q    <= 1'b0;
            posicao_q  <= '0;
        end else if (zera_s) begin
            estado_q   <= INATIVO;
            contador_q <= '0;
            pwm_q      <= 1'b0;
            fim_q      <= 1'b0;
            ativo_q    <= 1'b0;
            posicao_q  <= '0;
        end else begin
            case (estado_q)
                INATIVO: begin
                    fim_q <= 1'b0;
                    if (habilita) begin
                        posicao_q  <= posicao_sat;
                        contador_q <= '0;
                        pwm_q      <= 1'b1;
                        ativo_q    <= 1'b1;
                        estado_q   <= PULSO;
                    end
                end
                PULSO: begin
                    contador_q <= contador_inc;
                    fim_q      <= (contador_inc == ULTIMO);
                    if (contador_q == largura - W'(1)) begin
                        pwm_q    <= 1'b0;
                        estado_q <= ESPERA;
                    end
                end
                ESPERA: begin
                    if (contador_q == ULTIMO) begin
                        // Period boundary: the only point where a new position is accepted.
                        contador_q <= '0;
                        fim_q      <= 1'b0;
                        if (habilita) begin
                            posicao_q <= posicao_sat;
                            pwm_q     <= 1'b1;
                            estado_q  <= PULSO;
                        end else begin
                            posicao_q <= '0;
                            ativo_q   <= 1'b0;
                            estado_q  <= INATIVO;
                        end
                    end else begin
                        contador_q <= contador_inc;
                        fim_q      <= (contador_inc == ULTIMO);
                    end
                end
                default: begin
                    estado_q   <= INATIVO;
                    contador_q <= '0;
                    pwm_q      <= 1'b0;
                    fim_q      <= 1'b0;
                    ativo_q    <= 1'b0;
                    posicao_q  <= '0;
                end
            endcase
        end
    end

`ifdef SERVO_INVERTE_EN
    assign pwm = ~pwm_q;
`else
    assign pwm = pwm_q;
`endif
    assign fim_periodo   = fim_q;
    assign posicao_atual = posicao_q;
    assign ativo         = ativo_q;

endmodule
